// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares a single req/gnt/rvalid memory port between NUM_REQ requesters
// (for example I-cache refill, D-cache and debug). Arbitration is
// round-robin. A requester can hold the port with lock_i, which is useful
// for multi-word line refills. Every granted transaction records its owner
// in an in-order FIFO so that each memory response is routed back to the
// requester that issued it.
//
// Ports
//   clk, rst_n     clock (rising edge) and asynchronous active-low reset
//   req_i          per-requester request, held until granted
//   lock_i         per-requester request to keep the port after its grant
//   addr_i         per-requester address, slice [32*k +: 32]
//   wdata_i        per-requester write data, slice [32*k +: 32]
//   we_i, be_i     per-requester write enable and byte enables
//   gnt_o          one-hot grant to the requester that was accepted
//   rvalid_o       one-hot response valid to the owner of the response
//   rdata_o        shared response data, qualified by rvalid_o
//   error_o        shared response error, qualified by rvalid_o
//   mem_*_o        request towards the memory port
//   mem_gnt_i      memory grant
//   mem_rvalid_i   in-order memory response valid
//   mem_rdata_i    memory response data
//   mem_error_i    memory response error
//   spurious_o     sticky flag: a response arrived with nothing outstanding
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [NUM_REQ-1:0]     lock_i,
    input  logic [32*NUM_REQ-1:0]  addr_i,
    input  logic [32*NUM_REQ-1:0]  wdata_i,
    input  logic [NUM_REQ-1:0]     we_i,
    input  logic [4*NUM_REQ-1:0]   be_i,
    output logic [NUM_REQ-1:0]     gnt_o,
    output logic [NUM_REQ-1:0]     rvalid_o,
    output logic [31:0]            rdata_o,
    output logic                   error_o,
    output logic                   mem_req_o,
    output logic [31:0]            mem_addr_o,
    output logic [31:0]            mem_wdata_o,
    output logic                   mem_we_o,
    output logic [3:0]             mem_be_o,
    input  logic                   mem_gnt_i,
    input  logic                   mem_rvalid_i,
    input  logic [31:0]            mem_rdata_i,
    input  logic                   mem_error_i,
    output logic                   spurious_o
);

    localparam int IDW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNTW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTRW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam logic ST_ARB    = 1'b0;
    localparam logic ST_LOCKED = 1'b1;

    logic            state_q, state_d;
    logic [IDW-1:0]  lock_owner_q, lock_owner_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]  fifo_q [MAX_OUTSTANDING];
    logic [PTRW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0] count_q;
    logic            spurious_q;

    logic            win_valid;
    logic [IDW-1:0]  win_id;
    logic            fifo_full, fifo_empty;
    logic            push, pop;

    assign fifo_full  = (count_q == CNTW'(MAX_OUTSTANDING));
    assign fifo_empty = (count_q == '0);

    // In ARB the first requesting index at or after rr_ptr wins; in LOCKED
    // the owner is the only candidate, even if it is not requesting.
    always_comb begin
        logic [IDW-1:0] cand;
        int             idx;
        win_valid = 1'b0;
        win_id    = '0;
        cand      = '0;
        idx       = 0;
        if (state_q == ST_LOCKED) begin
            win_id    = lock_owner_q;
            win_valid = req_i[lock_owner_q];
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                idx = int'(rr_ptr_q) + i;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                cand = IDW'(idx);
                if (!win_valid && req_i[cand]) begin
                    win_valid = 1'b1;
                    win_id    = cand;
                end
            end
        end
    end

    // A full FIFO blocks new requests even if a response pops this cycle.
    assign mem_req_o = win_valid && !fifo_full;
    assign push      = mem_req_o && mem_gnt_i;
    assign pop       = mem_rvalid_i && !fifo_empty;

    assign mem_addr_o  = win_valid ? addr_i[32*win_id +: 32]  : '0;
    assign mem_wdata_o = win_valid ? wdata_i[32*win_id +: 32] : '0;
    assign mem_we_o    = win_valid ? we_i[win_id]             : 1'b0;
    assign mem_be_o    = win_valid ? be_i[4*win_id +: 4]      : '0;

    assign rdata_o    = mem_rdata_i;
    assign error_o    = mem_error_i;
    assign spurious_o = spurious_q;

    always_comb begin
        gnt_o    = '0;
        rvalid_o = '0;
        if (push) begin
            gnt_o[win_id] = 1'b1;
        end
        if (pop) begin
            rvalid_o[fifo_q[rd_ptr_q]] = 1'b1;
        end
    end

    // Lock is entered only on a grant and left as soon as the owner drops
    // lock_i; the pointer is frozen while locked.
    always_comb begin
        state_d      = state_q;
        lock_owner_d = lock_owner_q;
        rr_ptr_d     = rr_ptr_q;
        if (state_q == ST_ARB) begin
            if (push) begin
                rr_ptr_d = (win_id == IDW'(NUM_REQ - 1)) ? '0 : win_id + IDW'(1);
                if (lock_i[win_id]) begin
                    state_d      = ST_LOCKED;
                    lock_owner_d = win_id;
                end
            end
        end else begin
            if (!lock_i[lock_owner_q]) begin
                state_d = ST_ARB;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_ARB;
            lock_owner_q <= '0;
            rr_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            spurious_q   <= 1'b0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            lock_owner_q <= lock_owner_d;
            rr_ptr_q     <= rr_ptr_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= win_id;
                wr_ptr_q <= (wr_ptr_q == PTRW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + PTRW'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTRW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + PTRW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNTW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNTW'(1);
            end
            if (mem_rvalid_i && fifo_empty) begin
                spurious_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter with two requesters and two
// outstanding transactions. Inputs change on the falling edge and the
// combinational outputs are checked 1 time unit later, so state updated
// at a rising edge is visible in the following step.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_i;
    logic [1:0]  lock_i;
    logic [63:0] addr_i;
    logic [63:0] wdata_i;
    logic [1:0]  we_i;
    logic [7:0]  be_i;
    logic [1:0]  gnt_o;
    logic [1:0]  rvalid_o;
    logic [31:0] rdata_o;
    logic        error_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        mem_error_i;
    logic        spurious_o;

    int checks;
    int errors;

    logic [1:0]  expGnt;
    logic [1:0]  prevGnt;

    mem_port_arbiter #(
        .NUM_REQ         (2),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req_i),
        .lock_i       (lock_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .we_i         (we_i),
        .be_i         (be_i),
        .gnt_o        (gnt_o),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .error_o      (error_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .mem_error_i  (mem_error_i),
        .spurious_o   (spurious_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic [1:0] req, input logic [1:0] lock,
                                 input logic gnt, input logic rvalid,
                                 input logic [31:0] rdata, input logic err);
        @(negedge clk);
        req_i        = req;
        lock_i       = lock;
        mem_gnt_i    = gnt;
        mem_rvalid_i = rvalid;
        mem_rdata_i  = rdata;
        mem_error_i  = err;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        req_i        = '0;
        lock_i       = '0;
        addr_i       = {32'h0000_2B80, 32'h0000_1A40};
        wdata_i      = {32'hBBBB_0001, 32'hAAAA_0000};
        we_i         = 2'b10;
        be_i         = 8'hC3;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        mem_error_i  = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_gnt",      32'(gnt_o),      32'h0);
        checkOutput("rst_rvalid",   32'(rvalid_o),   32'h0);
        checkOutput("rst_mem_req",  32'(mem_req_o),  32'h0);
        checkOutput("rst_mem_addr", mem_addr_o,      32'h0);
        checkOutput("rst_spurious", 32'(spurious_o), 32'h0);
        rst_n = 1'b1;

        // Contention: grants alternate, responses follow one cycle later
        prevGnt = 2'b00;
        for (int i = 0; i < 6; i++) begin
            expGnt = (i % 2 == 0) ? 2'b01 : 2'b10;
            applyStimulus(2'b11, 2'b00, 1'b1, (i != 0), 32'hC0DE_0000 + 32'(i), 1'(i % 2));
            checkOutput($sformatf("cont_gnt_%0d", i),    32'(gnt_o),    32'(expGnt));
            checkOutput($sformatf("cont_rvalid_%0d", i), 32'(rvalid_o), 32'(prevGnt));
            checkOutput($sformatf("cont_addr_%0d", i), mem_addr_o,
                        (expGnt == 2'b01) ? 32'h0000_1A40 : 32'h0000_2B80);
            checkOutput($sformatf("cont_rdata_%0d", i), rdata_o, 32'hC0DE_0000 + 32'(i));
            checkOutput($sformatf("cont_err_%0d", i),   32'(error_o), 32'(i % 2));
            prevGnt = expGnt;
        end
        checkOutput("cont_we_last",    32'(mem_we_o),  32'h1);
        checkOutput("cont_be_last",    32'(mem_be_o),  32'hC);
        checkOutput("cont_wdata_last", mem_wdata_o,    32'hBBBB_0001);
        applyStimulus(2'b00, 2'b00, 1'b1, 1'b1, 32'h0, 1'b0);
        checkOutput("drain_rvalid",  32'(rvalid_o),  32'(prevGnt));
        checkOutput("drain_gnt",     32'(gnt_o),     32'h0);
        checkOutput("drain_mem_req", 32'(mem_req_o), 32'h0);

        // Full FIFO: two grants, then blocked until a response frees a slot
        applyStimulus(2'b01, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("full_g1", 32'(gnt_o), 32'h1);
        applyStimulus(2'b01, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("full_g2", 32'(gnt_o), 32'h1);
        applyStimulus(2'b01, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("full_mem_req", 32'(mem_req_o), 32'h0);
        checkOutput("full_gnt",     32'(gnt_o),     32'h0);
        applyStimulus(2'b01, 2'b00, 1'b1, 1'b1, 32'h0, 1'b0);
        checkOutput("full_pop_mem_req", 32'(mem_req_o), 32'h0);
        checkOutput("full_pop_gnt",     32'(gnt_o),     32'h0);
        checkOutput("full_pop_rvalid",  32'(rvalid_o),  32'h1);
        applyStimulus(2'b01, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("full_resume_mem_req", 32'(mem_req_o), 32'h1);
        checkOutput("full_resume_gnt",     32'(gnt_o),     32'h1);

        // Push/pop in the same cycle with one entry outstanding
        applyStimulus(2'b00, 2'b00, 1'b1, 1'b1, 32'h0, 1'b0);
        checkOutput("pp_pre_rvalid", 32'(rvalid_o), 32'h1);
        applyStimulus(2'b10, 2'b00, 1'b1, 1'b1, 32'h0, 1'b0);
        checkOutput("pp_gnt",    32'(gnt_o),    32'h2);
        checkOutput("pp_rvalid", 32'(rvalid_o), 32'h1);
        checkOutput("pp_addr",   mem_addr_o,    32'h0000_2B80);
        applyStimulus(2'b01, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("pp_count1_gnt",  32'(gnt_o),  32'h1);
        checkOutput("pp_count1_addr", mem_addr_o,  32'h0000_1A40);
        applyStimulus(2'b01, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("pp_now_full", 32'(mem_req_o), 32'h0);
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b1, 32'h0, 1'b0);
        checkOutput("pp_drain1", 32'(rvalid_o), 32'h2);
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b1, 32'h0, 1'b0);
        checkOutput("pp_drain2", 32'(rvalid_o), 32'h1);

        // Lock: requester 1 holds the port for four grants
        applyStimulus(2'b11, 2'b10, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("lock_g1", 32'(gnt_o), 32'h2);
        for (int i = 2; i <= 4; i++) begin
            applyStimulus(2'b11, 2'b10, 1'b1, 1'b1, 32'h0, 1'b0);
            checkOutput($sformatf("lock_g%0d", i),        32'(gnt_o),    32'h2);
            checkOutput($sformatf("lock_rvalid_%0d", i),  32'(rvalid_o), 32'h2);
        end
        applyStimulus(2'b01, 2'b00, 1'b1, 1'b1, 32'h0, 1'b0);
        checkOutput("lock_release_gnt",    32'(gnt_o),     32'h0);
        checkOutput("lock_release_memreq", 32'(mem_req_o), 32'h0);
        checkOutput("lock_release_rvalid", 32'(rvalid_o),  32'h2);
        applyStimulus(2'b01, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("lock_after_gnt", 32'(gnt_o), 32'h1);
        applyStimulus(2'b01, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("lock_second_outstanding", 32'(gnt_o), 32'h1);

        // Reset with two outstanding, then stale responses
        @(negedge clk);
        rst_n        = 1'b0;
        req_i        = 2'b00;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        #1;
        checkOutput("midrst_gnt",     32'(gnt_o),      32'h0);
        checkOutput("midrst_mem_req", 32'(mem_req_o),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b1, 32'h0, 1'b0);
        checkOutput("stale1_rvalid",   32'(rvalid_o),   32'h0);
        checkOutput("stale1_spurious", 32'(spurious_o), 32'h0);
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b1, 32'h0, 1'b0);
        checkOutput("stale2_rvalid",   32'(rvalid_o),   32'h0);
        checkOutput("stale2_spurious", 32'(spurious_o), 32'h1);
        applyStimulus(2'b11, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("resume_gnt",      32'(gnt_o),      32'h1);
        checkOutput("resume_spurious", 32'(spurious_o), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
